// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : la_pkg
//  Description : Shared types and constants for the logic-analyzer capture
//                path (acquisition state encoding, default RAM depth).
//  Revision    : 1.0  initial release
// ============================================================================
package la_pkg;

    // Acquisition sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        DONE = 2'd2
    } cap_state_t;

    // Sample-RAM entries per channel
    localparam int DEFAULT_DEPTH = 384;

endpackage
`default_nettype wire

// File: rtl/capture_ctrl_wrap_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_cntr
//  Description : Modulo-DEPTH address counter with synchronous clear and
//                count enable. DEPTH need not be a power of two, so the wrap
//                is done by comparing against DEPTH-1.
//  Revision    : 1.0  initial release
// ============================================================================
module wrap_cntr
    import la_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Clear has priority; otherwise advance and wrap LAST -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ctrl
//  Description : Sequences one logic-analyzer acquisition: fills pre-trigger
//                history, arms the trigger unit, counts post-trigger samples,
//                pulses completion and latches the trace end address.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_ctrl
    import la_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          wrt_smpl,
    input  logic          triggered,
    input  logic [AW-1:0] trig_pos,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          armed,
    output logic          set_capture_done,
    output logic          capture_done,
    output logic [AW-1:0] trace_end,
    output logic          busy
);

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    cap_state_t    state;
    cap_state_t    state_nxt;
    logic          start_acc;   // start accepted this cycle (IDLE/DONE, no abort)
    logic          complete;    // acquisition finishes this cycle
    logic [AW:0]   smpl_cnt;    // pre-trigger fill, saturates at DEPTH
    logic [AW:0]   smpl_inc;
    logic [AW:0]   arm_thresh;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] tp_eff;      // trig_pos clamped and held for the acquisition
    logic [AW-1:0] tp_clamp;
    logic [AW-1:0] last_addr;   // address of the most recent completed write

    assign smpl_inc   = smpl_cnt + (AW+1)'(1);
    assign arm_thresh = DEPTH_C - {1'b0, tp_eff};
    assign tp_clamp   = (trig_pos > LAST) ? LAST : trig_pos;
    assign last_addr  = (waddr == '0) ? LAST : waddr - AW'(1);

    // Write pointer; restarts at 0 for every acquisition
    wrap_cntr #(
        .DEPTH (DEPTH)
    ) u_waddr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .en    (we),
        .cnt   (waddr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and combinational outputs; abort overrides everything
    always_comb begin
        state_nxt        = state;
        start_acc        = 1'b0;
        complete         = 1'b0;
        we               = 1'b0;
        set_capture_done = 1'b0;
        busy             = (state == CAPT);
        capture_done     = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_nxt = CAPT;
                    start_acc = 1'b1;
                end
            end
            CAPT: begin
                // The write that would exceed tp_eff post samples is dropped
                complete = !abort && armed && triggered && (post_cnt == tp_eff);
                we       = !abort && wrt_smpl && !complete;
                if (complete) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        set_capture_done = complete;
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Acquisition counters, arming and trace end latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt  <= '0;
            post_cnt  <= '0;
            tp_eff    <= '0;
            armed     <= 1'b0;
            trace_end <= '0;
        end else if (abort) begin
            armed <= 1'b0;
        end else if (start_acc) begin
            smpl_cnt <= '0;
            post_cnt <= '0;
            tp_eff   <= tp_clamp;
            armed    <= 1'b0;
        end else if (state == CAPT) begin
            if (we) begin
                smpl_cnt <= (smpl_cnt == DEPTH_C) ? DEPTH_C : smpl_inc;
                if (smpl_inc >= arm_thresh) begin
                    armed <= 1'b1;
                end
                if (armed && triggered) begin
                    post_cnt <= post_cnt + AW'(1);
                end
            end
            if (complete) begin
                armed     <= 1'b0;
                trace_end <= last_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_ctrl
//  Description : Self-checking bench for capture_ctrl (DEPTH=16). A reference
//                model derives every output from acquisition-level counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_capture_ctrl;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, wrt_smpl, triggered;
    logic [3:0] trig_pos;
    logic       we, armed, set_capture_done, capture_done, busy;
    logic [3:0] waddr, trace_end;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: acquisition mode (0 idle, 1 capturing, 2 done),
    // writes made this acquisition, post-trigger writes, clamped trig_pos,
    // latched trace end.
    int m_mode, m_writes, m_post, m_tp, m_te;

    capture_ctrl #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .wrt_smpl         (wrt_smpl),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .capture_done     (capture_done),
        .trace_end        (trace_end),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_writes = 0; m_post = 0; m_tp = 0; m_te = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model
    task automatic cycle(input bit st, input bit ab, input bit ws, input bit tr);
        bit e_armed, e_cmp, e_we;
        @(negedge clk);
        start = st; abort = ab; wrt_smpl = ws; triggered = tr;
        #1;
        e_armed = (m_mode == 1) && (m_writes >= DEPTH - m_tp);
        e_cmp   = !ab && (m_mode == 1) && e_armed && tr && (m_post == m_tp);
        e_we    = (m_mode == 1) && ws && !ab && !e_cmp;
        chk("we",           32'(we),               32'(e_we));
        chk("waddr",        32'(waddr),            32'(m_writes % DEPTH));
        chk("armed",        32'(armed),            32'(e_armed));
        chk("set_cap_done", 32'(set_capture_done), 32'(e_cmp));
        chk("capture_done", 32'(capture_done),     32'(m_mode == 2));
        chk("busy",         32'(busy),             32'(m_mode == 1));
        chk("trace_end",    32'(trace_end),        32'(m_te));
        if (ab) begin
            m_mode = 0;
        end else if (m_mode != 1 && st) begin
            m_mode = 1; m_writes = 0; m_post = 0;
            m_tp = (int'(trig_pos) > DEPTH - 1) ? DEPTH - 1 : int'(trig_pos);
        end else if (m_mode == 1) begin
            if (e_cmp) begin
                m_mode = 2;
                m_te   = (m_writes + DEPTH - 1) % DEPTH;
            end
            if (e_we) begin
                if (e_armed && tr) m_post++;
                m_writes++;
            end
        end
    endtask

    // One acquisition. gap<0: random strobes; gap>=0: strobe every gap+1 cycles.
    // Trigger asserted trig_delay cycles after arming (or from the start).
    task automatic run(input int tp, input int trig_delay, input bit trig_early,
                       input int gap, input int abort_post, input bit rnd_start);
        int k = 0;
        bit arm_now, ws, tr, ab, st;
        trig_pos = 4'(tp);
        cycle(1'b1, 1'b0, 1'b0, trig_early);
        for (int i = 0; i < 200; i++) begin
            arm_now = (m_mode == 1) && (m_writes >= DEPTH - m_tp);
            if (gap < 0) ws = 1'($urandom_range(0, 1));
            else         ws = (i % (gap + 1)) == 0;
            tr = trig_early || (arm_now && k >= trig_delay);
            ab = (abort_post >= 0) && arm_now && tr && (m_post == abort_post);
            st = rnd_start && ($urandom_range(0, 7) == 0);
            if (arm_now) k++;
            cycle(st, ab, ws, tr);
            if (m_mode != 1) break;
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("end_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(we),               32'd0);
        chk({tag, "_waddr"}, 32'(waddr),            32'd0);
        chk({tag, "_armed"}, 32'(armed),            32'd0);
        chk({tag, "_scd"},   32'(set_capture_done), 32'd0);
        chk({tag, "_cd"},    32'(capture_done),     32'd0);
        chk({tag, "_tend"},  32'(trace_end),        32'd0);
        chk({tag, "_busy"},  32'(busy),             32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wrt_smpl = 1'b0;
        triggered = 1'b0; trig_pos = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // 1: trig_pos=4, trigger 3 cycles after arming
        run(4, 3, 1'b0, 0, -1, 1'b0);
        chk("t1_trace_end", 32'(trace_end), 32'd2);
        chk("t1_done", 32'(capture_done), 32'd1);

        // 2: trig_pos=0, 20 samples then trigger; waddr wraps once
        run(0, 4, 1'b0, 0, -1, 1'b0);
        chk("t2_trace_end", 32'(trace_end), 32'd3);

        // 3: trigger high from start; arming still waits for 12 writes
        run(4, 0, 1'b1, 0, -1, 1'b0);
        chk("t3_trace_end", 32'(trace_end), 32'd15);

        // 4: abort after 2 post-trigger samples
        run(4, 0, 1'b0, 0, 2, 1'b0);
        chk("t4_trace_end_kept", 32'(trace_end), 32'd15);
        chk("t4_not_done", 32'(capture_done), 32'd0);

        // 5: maximum trig_pos, strobes every 4th cycle
        run(31, 0, 1'b0, 3, -1, 1'b0);
        chk("t5_trace_end", 32'(trace_end), 32'd15);

        // start and abort together from DONE: abort wins
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_abort_busy", 32'(busy), 32'd0);

        // randomized acquisitions with stray start pulses during capture
        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                1'($urandom_range(0, 1)),
                (r % 2 == 0) ? -1 : int'($urandom_range(0, 2)), -1, 1'b1);
        end

        // 6: asynchronous reset mid-capture
        trig_pos = 4'd4;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(4, 0, 1'b1, 0, -1, 1'b0);
        chk("t6_trace_end", 32'(trace_end), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
